logical_tile_io_multi_mode: RTL

- Parametrised successor to the single-pad IO logical tile: NUM_IO GPIO channels behind one configuration chain.
- Each channel's direction, output registering and input synchronisation are set by configuration bits shifted in over ccff_head/ccff_tail.
- A load state machine validates chain length and holds all pads safe (tristated, inputs zero) until a complete load finishes.
- Sits at the fabric periphery between grid routing (io_outpad/io_inpad) and the Caravel GPIO pad cells.

---
 rtl/logical_tile_io_multi_mode_pkg.sv | 23 ++
 rtl/logical_tile_io_multi_mode_channel.sv | 67 ++++++
 rtl/logical_tile_io_multi_mode.sv | 119 +++++++++++
 3 files changed

// File: rtl/logical_tile_io_multi_mode_pkg.sv
// Shared definitions for the multi-channel IO logical tile.
// Optional feature macro: IO_LOOPBACK_EN (adds a per-channel loopback config bit).
package io_tile_pkg;

`ifdef IO_LOOPBACK_EN
  localparam int CFG_BITS = 4;
`else
  localparam int CFG_BITS = 3;
`endif

  // Positions of the per-channel configuration bits inside a channel slice
  localparam int CFG_OE_EN    = 0;
  localparam int CFG_OUT_REG  = 1;
  localparam int CFG_IN_SYNC  = 2;
  localparam int CFG_LOOPBACK = 3;

  typedef enum logic [1:0] {
    UNCONF  = 2'd0,
    LOADING = 2'd1,
    ACTIVE  = 2'd2
  } state_e;

endpackage

// File: rtl/logical_tile_io_multi_mode_channel.sv
// One GPIO channel: optional output register, optional input synchroniser,
// and the safe-state gating applied whenever the tile is not ACTIVE.
// Optional feature macro: IO_LOOPBACK_EN (internal loopback through the input path).
module io_tile_channel
  import io_tile_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active_i,
  input  logic [CFG_BITS-1:0] cfg_i,
  input  logic                outpad_i,
  input  logic                pad_a_i,
  output logic                pad_y_o,
  output logic                pad_oe_o,
  output logic                inpad_o
);

  logic                   out_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   y_data;
  logic                   in_src;
  logic                   loopback;

  // Output data after the optional one-cycle register
  assign y_data = cfg_i[CFG_OUT_REG] ? out_q : outpad_i;

`ifdef IO_LOOPBACK_EN
  // Loopback feeds the channel's own output data into the input path
  assign loopback = cfg_i[CFG_LOOPBACK];
  assign in_src   = loopback ? y_data : pad_a_i;
`else
  assign loopback = 1'b0;
  assign in_src   = pad_a_i;
`endif

  // Output register: runs only in ACTIVE, held clear otherwise so entry starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
    end else if (!active_i) begin
      out_q <= 1'b0;
    end else begin
      out_q <= outpad_i;
    end
  end

  // Input synchroniser chain: same clear-outside-ACTIVE behaviour as the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else if (!active_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_src;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign pad_oe_o = active_i & cfg_i[CFG_OE_EN] & ~loopback;
  assign pad_y_o  = active_i & y_data;
  assign inpad_o  = active_i & (cfg_i[CFG_IN_SYNC] ? sync_q[SYNC_STAGES-1] : in_src);

endmodule

// File: rtl/logical_tile_io_multi_mode.sv
// Multi-channel IO logical tile: serial configuration chain, load-validation
// FSM and NUM_IO GPIO channels held safe until a complete load finishes.
// Optional feature macro: IO_LOOPBACK_EN (4 config bits per channel instead of 3).
module logical_tile_io_multi_mode
  import io_tile_pkg::*;
#(
  parameter int NUM_IO      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad,
  input  logic [NUM_IO-1:0] gfpga_pad_GPIO_A,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_Y,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_OE,
  output logic              config_done,
  output logic              cfg_err
);

  localparam int CHAIN_LEN = NUM_IO * CFG_BITS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] chain_q;
  logic [CHAIN_LEN-1:0] chain_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  state_e               state_q;
  logic                 config_done_q;
  logic                 cfg_err_q;
  logic                 active;

  // The chain shifts whenever enabled, regardless of FSM state
  assign chain_d   = ccff_en ? {chain_q[CHAIN_LEN-2:0], ccff_head} : chain_q;
  assign ccff_tail = chain_q[CHAIN_LEN-1];

  // Saturate one past a full load so any overlong load stays distinguishable
  assign cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

  // Configuration shift register
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  // Load FSM: the entering shift edge counts as the first bit, length checked when ccff_en drops
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q       <= UNCONF;
      cnt_q         <= '0;
      config_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        UNCONF: begin
          if (ccff_en) begin
            state_q <= LOADING;
            cnt_q   <= CNT_ONE;
          end
        end
        LOADING: begin
          if (ccff_en) begin
            cnt_q <= cnt_d;
          end else if (cnt_q == CNT_FULL) begin
            state_q       <= ACTIVE;
            config_done_q <= 1'b1;
            cfg_err_q     <= 1'b0;
          end else begin
            state_q   <= UNCONF;
            cfg_err_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ccff_en) begin
            state_q       <= LOADING;
            cnt_q         <= CNT_ONE;
            config_done_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= UNCONF;
          config_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign active      = (state_q == ACTIVE);
  assign config_done = config_done_q;
  assign cfg_err     = cfg_err_q;

  generate
    for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_ch
      io_tile_channel #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_ch (
        .clk     (prog_clk),
        .rst_n   (pReset),
        .active_i(active),
        .cfg_i   (chain_q[CFG_BITS*gi +: CFG_BITS]),
        .outpad_i(io_outpad[gi]),
        .pad_a_i (gfpga_pad_GPIO_A[gi]),
        .pad_y_o (gfpga_pad_GPIO_Y[gi]),
        .pad_oe_o(gfpga_pad_GPIO_OE[gi]),
        .inpad_o (io_inpad[gi])
      );
    end
  endgenerate

endmodule
